uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised next-generation asynchronous UART receiver; replaces the fixed 7/8-bit receiver in the CoreUARTapb datapath.
- Generalised data width, oversampling ratio and stop-bit count.
- Adds a valid/ready output handshake with a one-deep holding register, per-word error tags and latched frame configuration.
- Sits between the pad-side rx line and the RX FIFO or APB register file; runs entirely on the system clock, gated by a baud-tick enable.

Parameters:
- DATA_WIDTH, 9: maximum data bits per frame; legal range 5..9.
- OVERSAMPLE, 16: baud_tick pulses per bit period; legal values 8 or 16.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- baud_tick  in  1  one-clk enable pulse at OVERSAMPLE x baud rate.
- rx  in  1  raw serial input, idle high, asynchronous to clk.
- cfg_data_bits  in  4  data bits per frame; values below 5 clamp to 5, values above DATA_WIDTH clamp to DATA_WIDTH.
- cfg_parity_en  in  1  1 = parity bit present.
- cfg_parity_odd  in  1  1 = odd parity, 0 = even parity.
- cfg_two_stop  in  1  1 = two stop bits checked.
- rx_ready  in  1  consumer accepts the word.
- clear_status  in  1  clears overflow (and break_det when compiled in).
- rx_data  out  DATA_WIDTH  received word, LSB-aligned, zero-extended.
- rx_valid  out  1  holding register is full.
- rx_parity_err  out  1  tag for rx_data: parity mismatch.
- rx_framing_err  out  1  tag for rx_data: a stop bit sampled 0.
- overflow  out  1  sticky; a word was dropped.
- rx_busy  out  1  state is not IDLE.
- break_det  out  1  sticky break flag (optional feature).

Behaviour:
- Reset: state IDLE, synchroniser flops = 1, rx_data = 0, rx_valid = 0, both tags = 0, overflow = 0, rx_busy = 0, break_det = 0.
- Reset asserted mid-frame: frame abandoned; nothing delivered; no flags set.
- rx passes through a 2-flop synchroniser (reset value 1). All further sampling happens only on cycles where baud_tick = 1.
- States: IDLE, START, DATA, PARITY, STOP. tick_cnt counts 0..OVERSAMPLE-1 within each bit period.
- IDLE -> START: synchronised rx = 0 on a tick. tick_cnt is cleared, and cfg_* are latched. Changes to cfg_* mid-frame have no effect on the current frame.
- Bit decision: the synchronised rx is sampled at tick_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the majority of the 3 samples, decided at tick OVERSAMPLE/2+1. The bit ends at tick_cnt = OVERSAMPLE-1.
- START: voted value 1 -> false start; return to IDLE with no flags set. Voted 0 -> DATA at end of the bit period.
- DATA: bits are received LSB first into bit index 0..n-1. After n bits, go to PARITY if cfg_parity_en = 1, otherwise go to STOP.
- PARITY: parity error = (XOR of data bits XOR parity bit) != cfg_parity_odd.
- STOP: one stop bit, or two when cfg_two_stop = 1. Any stop bit voted 0 sets the framing tag.
- The frame completes at the vote of the last stop bit (mid-bit). The state returns to IDLE on that tick so the next start edge can be detected early.
- Completion with rx_valid = 0, or rx_valid = 1 with rx_ready = 1 in the same cycle: load rx_data and the tags; rx_valid = 1 on the next cycle. No overflow is raised in the same-cycle case.
- Completion with rx_valid = 1 and rx_ready = 0: the new word is dropped, the holding register is unchanged, and overflow is set to 1.
- Handshake: rx_valid and rx_valid & rx_ready clear together. rx_data and the tags are stable while rx_valid = 1.
- clear_status = 1 clears the sticky flags. If a set event and clear_status occur in the same cycle, the set wins.
- Latency: rx_valid rises 1 clk after the tick of the last stop-bit vote.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- Defined: a frame whose start, data, parity (when present) and stop bits all vote 0 is a break.
  - The frame is not delivered, and break_det is set (sticky).
  - The receiver then waits in STOP until a whole bit period votes 1 before returning to IDLE. The break frame therefore causes no overflow and no framing tag.
- Undefined: break_det is tied to 0. A break frame is delivered as 0x000 with rx_framing_err = 1, and the receiver returns to IDLE normally.

Test Plan:
- Config 8N1, OVERSAMPLE = 16: send 0xA5 -> rx_data = 0x0A5, rx_valid = 1, both tags = 0. With rx_ready held at 1, rx_valid lasts 1 cycle.
- Config 7E1: send 0x35 with parity bit = 1 -> rx_data = 0x035, rx_parity_err = 1. Resend with parity bit = 0 -> rx_parity_err = 0.
- Config 9-bit, odd parity, two stop bits: send 0x1FF with the second stop bit = 0 -> rx_data = 0x1FF, rx_framing_err = 1.
- Hold rx_ready = 0 and send 0x11 then 0x22 -> rx_data stays 0x011 and overflow = 1. Pulse clear_status -> overflow = 0. Then rx_ready = 1 for one cycle -> rx_valid = 0.
- Drive a 3-tick low glitch on idle rx -> no frame, rx_busy returns to 0, rx_valid stays 0. Separately, assert reset mid-DATA -> all outputs at reset values and the next frame is received correctly.
- With UART_RX_BREAK_DET_EN defined: hold rx low for 2 frame times -> break_det = 1, rx_valid = 0. Release rx to high, then send 0x5A -> rx_data = 0x05A.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample majority vote per bit, one-deep valid/ready holding register,
// per-word parity/framing tags. Break detection is compiled in with `define UART_RX_BREAK_DET_EN.
module uart_rx_param #(
  parameter int DATA_WIDTH = 9,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic                  rx,
  input  logic [3:0]            cfg_data_bits,
  input  logic                  cfg_parity_en,
  input  logic                  cfg_parity_odd,
  input  logic                  cfg_two_stop,
  input  logic                  rx_ready,
  input  logic                  clear_status,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_parity_err,
  output logic                  rx_framing_err,
  output logic                  overflow,
  output logic                  rx_busy,
  output logic                  break_det
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] T_S0  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] T_S1  = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] T_V   = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] T_END = CW'(OVERSAMPLE - 1);
`ifdef UART_RX_BREAK_DET_EN
  localparam logic BREAK_EN = 1'b1;
`else
  localparam logic BREAK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic                  rx_meta, rx_sync;
  logic [CW-1:0]         tick_cnt;
  logic [1:0]            samp;
  logic [3:0]            bit_idx, n_bits, bits_clamped;
  logic                  par_en, par_odd, two_stop, stop_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_err, frm_err, all_zero, brk_wait;
  logic                  vote, at_vote, at_end, frame_done, frame_break;

  always_comb begin
    if (cfg_data_bits < 4'd5) begin
      bits_clamped = 4'd5;
    end else if (cfg_data_bits > 4'(DATA_WIDTH)) begin
      bits_clamped = 4'(DATA_WIDTH);
    end else begin
      bits_clamped = cfg_data_bits;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The last stop bit completes the frame at its vote, not at its end, so an early next start is seen.
  always_comb begin
    state_nxt   = state;
    frame_done  = 1'b0;
    frame_break = 1'b0;
    at_vote     = baud_tick && (tick_cnt == T_V);
    at_end      = baud_tick && (tick_cnt == T_END);
    vote        = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);
    case (state)
      IDLE: begin
        if (baud_tick && !rx_sync) state_nxt = START;
        else                       state_nxt = IDLE;
      end
      START: begin
        if (at_vote && vote) state_nxt = IDLE;
        else if (at_end)     state_nxt = DATA;
        else                 state_nxt = START;
      end
      DATA: begin
        if (at_end && (bit_idx == n_bits)) state_nxt = par_en ? PARITY : STOP;
        else                               state_nxt = DATA;
      end
      PARITY: begin
        if (at_end) state_nxt = STOP;
        else        state_nxt = PARITY;
      end
      STOP: begin
        if (brk_wait) begin
          if (baud_tick && rx_sync && (tick_cnt == T_END)) state_nxt = IDLE;
          else                                             state_nxt = STOP;
        end else if (at_vote && (stop_idx == two_stop)) begin
          frame_done  = 1'b1;
          frame_break = BREAK_EN && all_zero && !vote;
          if (frame_break) state_nxt = STOP;
          else             state_nxt = IDLE;
        end else begin
          state_nxt = STOP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath; configuration is captured on the start edge and held for the whole frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      samp     <= 2'b11;
      bit_idx  <= 4'd0;
      n_bits   <= 4'd5;
      par_en   <= 1'b0;
      par_odd  <= 1'b0;
      two_stop <= 1'b0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      all_zero <= 1'b0;
      brk_wait <= 1'b0;
    end else if (baud_tick) begin
      if (state == IDLE) begin
        if (!rx_sync) begin
          tick_cnt <= '0;
          bit_idx  <= 4'd0;
          n_bits   <= bits_clamped;
          par_en   <= cfg_parity_en;
          par_odd  <= cfg_parity_odd;
          two_stop <= cfg_two_stop;
          stop_idx <= 1'b0;
          shreg    <= '0;
          par_err  <= 1'b0;
          frm_err  <= 1'b0;
          all_zero <= 1'b1;
          brk_wait <= 1'b0;
        end
      end else if (brk_wait) begin
        // After a break, tick_cnt counts consecutive high ticks until a full idle bit is seen.
        if (rx_sync) tick_cnt <= tick_cnt + CW'(1);
        else         tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + CW'(1);
        if (tick_cnt == T_S0) samp[0] <= rx_sync;
        if (tick_cnt == T_S1) samp[1] <= rx_sync;
        if (tick_cnt == T_V) begin
          if (vote) all_zero <= 1'b0;
          case (state)
            DATA: begin
              shreg   <= shreg | (DATA_WIDTH'(vote) << bit_idx);
              bit_idx <= bit_idx + 4'd1;
            end
            PARITY: par_err <= ((^shreg) ^ vote) != par_odd;
            STOP: begin
              if (!vote) frm_err <= 1'b1;
              if (frame_break) begin
                brk_wait <= 1'b1;
                tick_cnt <= '0;
              end
            end
            default: ;
          endcase
        end
        if ((tick_cnt == T_END) && (state == STOP)) stop_idx <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      rx_parity_err  <= 1'b0;
      rx_framing_err <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      if (frame_done && !frame_break && (!rx_valid || rx_ready)) begin
        rx_data        <= shreg;
        rx_valid       <= 1'b1;
        rx_parity_err  <= par_err;
        rx_framing_err <= frm_err | !vote;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (frame_done && !frame_break && rx_valid && !rx_ready) overflow <= 1'b1;
      else if (clear_status)                                   overflow <= 1'b0;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          break_det <= 1'b0;
    else if (frame_done && frame_break) break_det <= 1'b1;
    else if (clear_status)              break_det <= 1'b0;
  end
`else
  assign break_det = 1'b0;
`endif

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised scoreboard bench for uart_rx_param: frames are built from their bit list, expected
// words are queued at send time and popped by a monitor on every valid/ready handshake.
`timescale 1ns/1ps
module tb_uart_rx_param;
  localparam int DW       = 9;
  localparam int OS       = 16;
  localparam int TICK_DIV = 2;
  localparam int BIT_CLK  = OS * TICK_DIV;
`ifdef UART_RX_BREAK_DET_EN
  localparam bit BREAK_EN = 1'b1;
`else
  localparam bit BREAK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          baud_tick = 1'b0;
  logic          rx = 1'b1;
  logic [3:0]    cfg_data_bits = 4'd8;
  logic          cfg_parity_en = 1'b0;
  logic          cfg_parity_odd = 1'b0;
  logic          cfg_two_stop = 1'b0;
  logic          rx_ready = 1'b1;
  logic          clear_status = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_parity_err, rx_framing_err, overflow, rx_busy, break_det;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
  } exp_t;

  exp_t sb[$];
  exp_t popped;
  int   total = 0;
  int   bad = 0;
  int   run_len = 0;
  int   last_len = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx),
    .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd), .cfg_two_stop(cfg_two_stop),
    .rx_ready(rx_ready), .clear_status(clear_status),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
    .rx_framing_err(rx_framing_err), .overflow(overflow), .rx_busy(rx_busy),
    .break_det(break_det)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    cyc(BIT_CLK);
  endtask

  // Build the frame, predict the delivered word from the frame rules, then drive it.
  task automatic send_frame(input logic [8:0] d, input logic [3:0] cb, input logic pe,
                            input logic po, input logic ts, input logic pbit,
                            input logic s1, input logic s2, input bit deliver, input bit scramble);
    int            nb;
    logic [DW-1:0] dm;
    logic          pr;
    logic          allz;
    exp_t          e;
    nb = (cb < 4'd5) ? 5 : ((cb > 4'(DW)) ? DW : int'(cb));
    dm = '0;
    pr = 1'b0;
    for (int i = 0; i < nb; i++) begin
      dm[i] = d[i];
      pr    = pr ^ d[i];
    end
    allz   = (dm == '0) && !(pe && pbit) && !s1 && !(ts && s2);
    e.data = dm;
    e.perr = pe && ((pr ^ pbit) != po);
    e.ferr = !s1 || (ts && !s2);
    if (deliver && !(BREAK_EN && allz)) sb.push_back(e);
    cfg_data_bits  = cb;
    cfg_parity_en  = pe;
    cfg_parity_odd = po;
    cfg_two_stop   = ts;
    drive_bit(1'b0);
    if (scramble) begin
      cfg_data_bits  = 4'($urandom);
      cfg_parity_en  = 1'($urandom);
      cfg_parity_odd = 1'($urandom);
      cfg_two_stop   = 1'($urandom);
    end
    for (int i = 0; i < nb; i++) drive_bit(dm[i]);
    if (pe) drive_bit(pbit);
    drive_bit(s1);
    if (ts) drive_bit(s2);
    rx = 1'b1;
    cyc(2 * BIT_CLK);
  endtask

  initial begin
    forever begin
      for (int i = 0; i < TICK_DIV; i++) begin
        @(posedge clk);
        #1;
        baud_tick = (i == 0);
      end
    end
  end

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      run_len = 0;
    end else begin
      if (rx_valid) begin
        run_len++;
      end else if (run_len != 0) begin
        last_len = run_len;
        run_len  = 0;
      end
      if (rx_valid && rx_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word actual=0x%0h required=none", rx_data);
        end else begin
          popped = sb.pop_front();
          check("word_data", 32'(rx_data), 32'(popped.data));
          check("word_parity_err", 32'(rx_parity_err), 32'(popped.perr));
          check("word_framing_err", 32'(rx_framing_err), 32'(popped.ferr));
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] rd;
    logic [3:0] rcb;
    cyc(5);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_perr", 32'(rx_parity_err), 32'd0);
    check("rst_ferr", 32'(rx_framing_err), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_break", 32'(break_det), 32'd0);
    reset = 1'b0;
    cyc(5);

    send_frame(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("valid_len_8n1", 32'(last_len), 32'd1);
    send_frame(9'h035, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(9'h035, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(9'h1FF, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    rx_ready = 1'b0;
    send_frame(9'h011, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(9'h022, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("ovf_hold_data", 32'(rx_data), 32'h011);
    check("ovf_hold_valid", 32'(rx_valid), 32'd1);
    check("ovf_flag_set", 32'(overflow), 32'd1);
    clear_status = 1'b1;
    cyc(1);
    clear_status = 1'b0;
    check("ovf_flag_clear", 32'(overflow), 32'd0);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    check("ovf_valid_drop", 32'(rx_valid), 32'd0);
    rx_ready = 1'b1;

    rx = 1'b0;
    cyc(3 * TICK_DIV);
    rx = 1'b1;
    cyc(4);
    check("glitch_busy_rise", 32'(rx_busy), 32'd1);
    for (int i = 0; i < 2 * BIT_CLK && rx_busy; i++) cyc(1);
    check("glitch_busy_fall", 32'(rx_busy), 32'd0);
    check("glitch_no_valid", 32'(rx_valid), 32'd0);
    cyc(BIT_CLK);

`ifdef UART_RX_BREAK_DET_EN
    cfg_data_bits = 4'd8;
    cfg_parity_en = 1'b0;
    cfg_two_stop  = 1'b0;
    rx = 1'b0;
    cyc(20 * BIT_CLK);
    check("break_set", 32'(break_det), 32'd1);
    check("break_no_valid", 32'(rx_valid), 32'd0);
    check("break_wait_busy", 32'(rx_busy), 32'd1);
    rx = 1'b1;
    cyc(2 * BIT_CLK);
    check("break_release_idle", 32'(rx_busy), 32'd0);
    send_frame(9'h05A, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    clear_status = 1'b1;
    cyc(1);
    clear_status = 1'b0;
    check("break_clear", 32'(break_det), 32'd0);
`else
    send_frame(9'h000, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("break_tied_low", 32'(break_det), 32'd0);
`endif

    cfg_data_bits = 4'd8;
    cfg_parity_en = 1'b0;
    cfg_two_stop  = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    check("midreset_busy", 32'(rx_busy), 32'd1);
    reset = 1'b1;
    rx    = 1'b1;
    cyc(3);
    check("midreset_busy_clr", 32'(rx_busy), 32'd0);
    check("midreset_valid", 32'(rx_valid), 32'd0);
    check("midreset_data", 32'(rx_data), 32'd0);
    check("midreset_ovf", 32'(overflow), 32'd0);
    check("midreset_break", 32'(break_det), 32'd0);
    reset = 1'b0;
    cyc(5);
    send_frame(9'h03C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    for (int k = 0; k < 25; k++) begin
      rd  = 9'($urandom);
      rcb = 4'($urandom_range(0, 15));
      send_frame(rd, rcb, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0), 1'b1, 1'b1);
    end

    cyc(BIT_CLK);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
